sweep_cmd_writer: RTL
=====================

# sweep_cmd_writer

Byte-stream command assembler and writer end of the sweeper instruction FIFO. Receives framed host bytes (from the UART/SPI byte receiver), assembles each frame into one 88-bit sweep/PLL instruction word, validates it, and pushes it into the instruction FIFO that `frequency_sweeper` drains. Runs on the 50 MHz system clock alongside the sweeper.

## Interface
- `TIMEOUT_CYCLES`, default 50000: max idle cycles between bytes inside a frame (1 ms at 50 MHz).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid; byte accepted on cycle with `rx_valid & rx_ready`.
- `rx_ready`  out  1  assembler can accept a byte.
- `fifo_data`  out  88  instruction word to FIFO.
- `fifo_wr_en`  out  1  FIFO write strobe, one cycle per word.
- `fifo_full`  in  1  FIFO full status.
- `frame_err`  out  1  one-cycle pulse on rejected or aborted frame.
- `err_code`  out  2  last error: 0 none, 1 timeout, 2 checksum, 3 reserved bits set; holds until next error or reset.
- `cmd_count`  out  16  words written to FIFO, wraps 0xFFFF→0.

## Operation
- Instruction word layout: [87:81] reserved (must be 0), [80:49] init_freq, [48:33] cycles_per_step, [32:1] freq_step, [0] mode_select (0 sweep, 1 PLL).
- Frame: `SYNC_BYTE`, 11 payload bytes MSB first (first byte → [87:80]), then checksum byte = XOR of the 11 payload bytes (see Configuration).
- States: HUNT, PAYLOAD, CHECK, WRITE.
- HUNT: `rx_ready`=1; non-sync bytes discarded silently; sync byte → PAYLOAD, byte index 0.
- PAYLOAD: shift each accepted byte into 88-bit shift register, update running XOR; after 11th byte → CHECK. Sync-valued bytes here are data.
- CHECK: accept checksum byte; mismatch → err 2; reserved bits nonzero → err 3 (checksum error takes priority); either error → HUNT with `frame_err` pulse; else → WRITE.
- WRITE: `rx_ready`=0; `fifo_wr_en` = (state==WRITE) & ~`fifo_full`; on write: `cmd_count`+1, → HUNT. `fifo_data` register stable throughout WRITE.
- Timeout: idle counter runs only in PAYLOAD/CHECK, cleared on every accepted byte; reaching `TIMEOUT_CYCLES` → HUNT, err 1, `frame_err` pulse. No timeout in WRITE (waits on `fifo_full` indefinitely).
- Reset mid-frame or in WRITE: partial/pending word discarded, nothing written.

## Timing
- Reset values: `rx_ready`=0 during reset, 1 first cycle after; `fifo_data`=0, `fifo_wr_en`=0, `frame_err`=0, `err_code`=0, `cmd_count`=0, state HUNT.
- Final byte accepted in cycle N → state WRITE at N+1; `fifo_wr_en` high in N+1 if `fifo_full` low, else first later cycle with `fifo_full` low.
- `fifo_wr_en` never high two consecutive cycles; `rx_ready` low for every cycle in WRITE including the write cycle.
- `frame_err` pulses the cycle after the erroring byte/timeout; `err_code` updates the same cycle.
- Back-to-back frames: next sync byte acceptable the cycle after the write.

## Configuration
- `CMD_CHECKSUM_EN` defined: frame = sync + 11 payload + checksum; CHECK state verifies XOR, err 2 possible.
- Not defined: no checksum byte; 11th payload byte goes directly to reserved-bit check and WRITE; err 2 never produced; running XOR logic removed.

## Test plan
- Reset: hold `reset` 3 cycles mid-PAYLOAD → all outputs at reset values, `rx_ready`=1 next cycle, no FIFO write ever issued for partial frame.
- Good frame (init_freq 0x12345678, cycles_per_step 0x0064, freq_step 0x00000100, mode 0, correct XOR) with `fifo_full`=0 → `fifo_wr_en` one cycle at N+1, `fifo_data[80:49]`=0x12345678, `[48:33]`=0x0064, `[32:1]`=0x00000100, `[0]`=0, `cmd_count`=1.
- Same frame, `fifo_full` high 20 cycles after last byte → `rx_ready`=0, no write for 20 cycles, write on first full-low cycle, `fifo_data` unchanged throughout.
- Checksum byte XORed with 0x01 → `frame_err` pulse, `err_code`=2, no write, `cmd_count` unchanged; following valid frame written normally.
- First payload byte 0x80 with valid checksum → `err_code`=3, no write.
- Stop after 5 payload bytes for `TIMEOUT_CYCLES` cycles → `err_code`=1, state HUNT; leading garbage bytes 0x00, 0x5A then valid frame → exactly one write, `cmd_count`+1.

Source files
------------

// File: rtl/sweep_cmd_writer_if.sv
// Byte-receiver and instruction-FIFO write signals of sweep_cmd_writer.
// master: host/byte-receiver plus FIFO side (drives bytes and full flag).
// slave : the command writer itself.
interface sweep_cmd_writer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [87:0] fifo_data;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  fifo_data,
    input  fifo_wr_en,
    output fifo_full
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output fifo_data,
    output fifo_wr_en,
    input  fifo_full
  );
endinterface

// File: rtl/sweep_cmd_writer.sv
// sweep_cmd_writer: assembles framed host bytes into 88-bit sweep/PLL
// instruction words, validates them and pushes them into the sweeper FIFO.
// Frame: SYNC_BYTE, 11 payload bytes MSB first, then (with CMD_CHECKSUM_EN
// defined) an XOR checksum byte over the payload.
// Optional feature macro: CMD_CHECKSUM_EN (undefined = no checksum byte).
module sweep_cmd_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  sweep_cmd_writer_if.slave    bus,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [15:0]          cmd_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_ZERO = CNT_W'(0);
  localparam logic [3:0]       LAST_IDX  = 4'd10;

`ifdef CMD_CHECKSUM_EN
  // All 11 payload bytes live in the shift register before the checksum byte.
  localparam int unsigned SHIFT_W = 88;
`else
  // The 11th payload byte is used straight from rx_data, so 10 bytes suffice.
  localparam int unsigned SHIFT_W = 80;
`endif

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_RESERVED = 2'd3;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    WRITE   = 2'd3
  } state_t;

  // True when the reserved field of an instruction word is all zero.
  function automatic logic reserved_clear(input logic [6:0] rsv);
    return ~|rsv;
  endfunction

`ifdef CMD_CHECKSUM_EN
  // Running frame checksum: XOR of all payload bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [7:0]         csum_r;
`endif

  state_t             state_r;
  logic [3:0]         byte_idx_r;
  logic [SHIFT_W-1:0] shift_r;
  logic [CNT_W-1:0]   idle_cnt_r;
  logic [87:0]        fifo_data_r;
  logic               rx_ready_r;
  logic               frame_err_r;
  logic [1:0]         err_code_r;
  logic [15:0]        cmd_count_r;

  logic               rx_ready_s;
  logic               accept_s;
  logic               write_s;
  logic               idle_expired_s;
  logic [87:0]        word_s;

  // Ready is forced low while reset is asserted so no byte is taken during
  // reset, yet comes up high on the very first cycle after it.
  assign rx_ready_s     = rx_ready_r & ~reset;
  assign accept_s       = bus.rx_valid & rx_ready_s;
  assign write_s        = (state_r == WRITE) & ~bus.fifo_full;
  assign idle_expired_s = ~accept_s & (idle_cnt_r == IDLE_LAST);

`ifdef CMD_CHECKSUM_EN
  assign word_s = shift_r;
`else
  assign word_s = {shift_r, bus.rx_data};
`endif

  assign bus.rx_ready   = rx_ready_s;
  assign bus.fifo_data  = fifo_data_r;
  assign bus.fifo_wr_en = write_s;
  assign frame_err      = frame_err_r;
  assign err_code       = err_code_r;
  assign cmd_count      = cmd_count_r;

  // Frame assembly FSM: hunt for sync, collect payload, validate, write FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= HUNT;
      byte_idx_r  <= 4'd0;
      shift_r     <= {SHIFT_W{1'b0}};
      idle_cnt_r  <= IDLE_ZERO;
      fifo_data_r <= 88'd0;
      rx_ready_r  <= 1'b1;
      frame_err_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      cmd_count_r <= 16'd0;
`ifdef CMD_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        HUNT: begin
          rx_ready_r <= 1'b1;
          idle_cnt_r <= IDLE_ZERO;
          if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
            state_r    <= PAYLOAD;
            byte_idx_r <= 4'd0;
`ifdef CMD_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
          end else begin
            state_r <= HUNT;
          end
        end

        PAYLOAD: begin
          if (accept_s) begin
            idle_cnt_r <= IDLE_ZERO;
            shift_r    <= {shift_r[SHIFT_W-9:0], bus.rx_data};
            byte_idx_r <= byte_idx_r + 4'd1;
`ifdef CMD_CHECKSUM_EN
            csum_r     <= csum_next(csum_r, bus.rx_data);
            if (byte_idx_r == LAST_IDX) begin
              state_r <= CHECK;
            end else begin
              state_r <= PAYLOAD;
            end
`else
            if (byte_idx_r == LAST_IDX) begin
              if (!reserved_clear(word_s[87:81])) begin
                state_r     <= HUNT;
                frame_err_r <= 1'b1;
                err_code_r  <= ERR_RESERVED;
              end else begin
                state_r     <= WRITE;
                rx_ready_r  <= 1'b0;
                fifo_data_r <= word_s;
              end
            end else begin
              state_r <= PAYLOAD;
            end
`endif
          end else if (idle_expired_s) begin
            state_r     <= HUNT;
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TIMEOUT;
            idle_cnt_r  <= IDLE_ZERO;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
          end
        end

`ifdef CMD_CHECKSUM_EN
        CHECK: begin
          if (accept_s) begin
            idle_cnt_r <= IDLE_ZERO;
            if (bus.rx_data != csum_r) begin
              state_r     <= HUNT;
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_CHECKSUM;
            end else if (!reserved_clear(word_s[87:81])) begin
              state_r     <= HUNT;
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_RESERVED;
            end else begin
              state_r     <= WRITE;
              rx_ready_r  <= 1'b0;
              fifo_data_r <= word_s;
            end
          end else if (idle_expired_s) begin
            state_r     <= HUNT;
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TIMEOUT;
            idle_cnt_r  <= IDLE_ZERO;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
          end
        end
`endif

        WRITE: begin
          // No timeout here: the word waits for FIFO space indefinitely.
          idle_cnt_r <= IDLE_ZERO;
          if (write_s) begin
            state_r     <= HUNT;
            rx_ready_r  <= 1'b1;
            cmd_count_r <= cmd_count_r + 16'd1;
          end else begin
            state_r    <= WRITE;
            rx_ready_r <= 1'b0;
          end
        end

        default: begin
          state_r    <= HUNT;
          rx_ready_r <= 1'b1;
          idle_cnt_r <= IDLE_ZERO;
        end
      endcase
    end
  end

endmodule
